// File: rtl/seq_trig_pkg.sv
// -----------------------------------------------------------------------------
// seq_trig_pkg
// Shared types and default constants for the multi-channel sequence trigger.
//   chan_state_e : per-channel FSM state (IDLE waits for a load rise,
//                  ARMED waits for done inside the latched window)
//   *_DEF        : default values of the NCH / WIN_W / CNT_W parameters
// -----------------------------------------------------------------------------
package seq_trig_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } chan_state_e;

   localparam int NCH_DEF   = 4;
   localparam int WIN_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

endpackage : seq_trig_pkg

// File: rtl/seq_trig_chan.sv
// -----------------------------------------------------------------------------
// seq_trig_chan
// One independent load/done channel. A rising load_mem opens a window of
// win_len cycles. The first done inside that window is a hit and pulses
// ready. If the window runs out first, that is a miss and pulses timeout.
// Each hit also bumps a saturating counter.
//
// Optional feature macro: SEQ_TRIG_TIMEOUT_EN
//   defined   -> timeout is a registered one-cycle miss pulse
//   undefined -> timeout is tied to 0 (hit behaviour identical)
//
// Ports
//   clk      in   posedge clock
//   rst_n    in   asynchronous active-low reset
//   load_mem in   load request level for this channel
//   done     in   load-complete indication for this channel
//   win_len  in   window length, latched when the channel arms
//   cnt_clr  in   synchronous clear of the hit counter (beats increment)
//   ready    out  one-cycle hit pulse (registered)
//   timeout  out  one-cycle miss pulse (registered, macro-gated)
//   hit_cnt  out  saturating hit counter
// -----------------------------------------------------------------------------
module seq_trig_chan
   import seq_trig_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_mem,
   input  logic             done,
   input  logic [WIN_W-1:0] win_len,
   input  logic             cnt_clr,
   output logic             ready,
   output logic             timeout,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   chan_state_e      state_r;
   chan_state_e      state_s;
   logic             prev_load_r;
   logic             rise_s;
   logic             hit_s;
   logic             miss_s;
   logic             arm_s;
   logic [WIN_W-1:0] win_r;
   logic [WIN_W-1:0] count_r;
   logic             ready_r;
   logic [CNT_W-1:0] hit_cnt_r;

   // The load history resets to 0, so a load already high at the first edge
   // after reset counts as a rise.
   assign rise_s = load_mem & ~prev_load_r;

   // State register and previous-load history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         prev_load_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         prev_load_r <= load_mem;
      end
   end

   // Next-state decode: arm on a rise without done when the window is nonzero.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (rise_s && !done && (win_len != WIN_W'(0))) begin
               state_s = ARMED;
            end else begin
               state_s = IDLE;
            end
         end
         ARMED: begin
            if (done || (count_r == win_r)) begin
               state_s = IDLE;
            end else begin
               state_s = ARMED;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Outcome decode for this edge: hit, miss, or start a new window.
   // Rises seen while ARMED are ignored on purpose.
   always_comb begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
      arm_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               if (done) begin
                  hit_s = 1'b1;
               end else if (win_len == WIN_W'(0)) begin
                  // A zero window only accepts done on the rise edge itself.
                  miss_s = 1'b1;
               end else begin
                  arm_s = 1'b1;
               end
            end else begin
               arm_s = 1'b0;
            end
         end
         ARMED: begin
            if (done) begin
               hit_s = 1'b1;
            end else if (count_r == win_r) begin
               miss_s = 1'b1;
            end else begin
               miss_s = 1'b0;
            end
         end
         default: begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
            arm_s  = 1'b0;
         end
      endcase
   end

   // Window latch and elapsed-cycle counter. The rise edge is cycle 1, so a
   // miss happens exactly win_len edges after the rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_r   <= WIN_W'(0);
         count_r <= WIN_W'(0);
      end else if (arm_s) begin
         win_r   <= win_len;
         count_r <= WIN_W'(1);
      end else if ((state_r == ARMED) && !hit_s && !miss_s) begin
         count_r <= count_r + WIN_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Registered hit pulse and saturating hit counter. Clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r   <= 1'b0;
         hit_cnt_r <= CNT_W'(0);
      end else begin
         ready_r <= hit_s;
         if (cnt_clr) begin
            hit_cnt_r <= CNT_W'(0);
         end else if (hit_s && (hit_cnt_r != CNT_MAX)) begin
            hit_cnt_r <= hit_cnt_r + CNT_W'(1);
         end else begin
            hit_cnt_r <= hit_cnt_r;
         end
      end
   end

`ifdef SEQ_TRIG_TIMEOUT_EN
   logic timeout_r;

   // Registered miss pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= miss_s;
      end
   end

   assign timeout = timeout_r;
`else
   assign timeout = 1'b0;
`endif

   assign ready   = ready_r;
   assign hit_cnt = hit_cnt_r;

endmodule : seq_trig_chan

// File: rtl/multi_seq_trigger.sv
// -----------------------------------------------------------------------------
// multi_seq_trigger
// NCH independent sequence-trigger channels that share one window length.
// Each channel is a seq_trig_chan instance.
//
// Optional feature macro: SEQ_TRIG_TIMEOUT_EN (enables the timeout pulses)
//
// Ports
//   clk       in   posedge clock
//   rst_n     in   asynchronous active-low reset
//   load_mem  in   [NCH]       per-channel load request level
//   done      in   [NCH]       per-channel load-complete indication
//   win_len   in   [WIN_W]     window length, latched per channel at arm
//   cnt_clr   in   1           synchronous clear of all hit counters
//   ready     out  [NCH]       one-cycle per-channel hit pulse
//   ready_any out  1           OR of ready
//   timeout   out  [NCH]       one-cycle per-channel miss pulse
//   hit_cnt   out  [NCH*CNT_W] packed hit counters, channel 0 in the LSBs
// -----------------------------------------------------------------------------
module multi_seq_trigger
   import seq_trig_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     load_mem,
   input  logic [NCH-1:0]     done,
   input  logic [WIN_W-1:0]   win_len,
   input  logic               cnt_clr,
   output logic [NCH-1:0]     ready,
   output logic               ready_any,
   output logic [NCH-1:0]     timeout,
   output logic [NCH*CNT_W-1:0] hit_cnt
);

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_chan
         seq_trig_chan #(
            .WIN_W (WIN_W),
            .CNT_W (CNT_W)
         ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_mem (load_mem[g]),
            .done     (done[g]),
            .win_len  (win_len),
            .cnt_clr  (cnt_clr),
            .ready    (ready[g]),
            .timeout  (timeout[g]),
            .hit_cnt  (hit_cnt[g*CNT_W +: CNT_W])
         );
      end
   endgenerate

   // ready is already registered in each channel, so the OR stays combinational.
   assign ready_any = |ready;

endmodule : multi_seq_trigger

// File: tb/tb_multi_seq_trigger.sv
module tb_multi_seq_trigger;

   localparam int NCH   = 4;
   localparam int WIN_W = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_TRIG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                 clk;
   logic                 rst_n;
   logic [NCH-1:0]       load_mem;
   logic [NCH-1:0]       done;
   logic [WIN_W-1:0]     win_len;
   logic                 cnt_clr;
   logic [NCH-1:0]       ready;
   logic                 ready_any;
   logic [NCH-1:0]       timeout;
   logic [NCH*CNT_W-1:0] hit_cnt;

   multi_seq_trigger #(.NCH(NCH), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_mem  (load_mem),
      .done      (done),
      .win_len   (win_len),
      .cnt_clr   (cnt_clr),
      .ready     (ready),
      .ready_any (ready_any),
      .timeout   (timeout),
      .hit_cnt   (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: each channel is either waiting, or waiting for done
   // until an absolute deadline edge number.
   bit m_prev     [NCH];
   bit m_armed    [NCH];
   int m_deadline [NCH];
   int m_cnt      [NCH];
   bit m_ready    [NCH];
   bit m_to       [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_prev[i] = 1'b0; m_armed[i] = 1'b0; m_deadline[i] = 0;
         m_cnt[i] = 0; m_ready[i] = 1'b0; m_to[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit rise, hit, miss;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         rise = load_mem[i] && !m_prev[i];
         hit  = 1'b0;
         miss = 1'b0;
         if (m_armed[i]) begin
            if (done[i]) hit = 1'b1;
            else if (cyc == m_deadline[i]) miss = 1'b1;
            if (hit || miss) m_armed[i] = 1'b0;
         end else if (rise) begin
            if (done[i]) hit = 1'b1;
            else if (win_len == 0) miss = 1'b1;
            else begin
               m_armed[i]    = 1'b1;
               m_deadline[i] = cyc + int'(win_len);
            end
         end
         m_prev[i]  = load_mem[i];
         m_ready[i] = hit;
         m_to[i]    = miss;
         if (cnt_clr) m_cnt[i] = 0;
         else if (hit && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
   endtask

   task automatic compare_all();
      logic [NCH-1:0]       er, et;
      logic [NCH*CNT_W-1:0] ec;
      for (int i = 0; i < NCH; i++) begin
         er[i] = m_ready[i];
         et[i] = m_to[i] & TO_EN;
         ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      end
      chk("ready", 32'(ready), 32'(er));
      chk("ready_any", 32'(ready_any), 32'(|er));
      chk("timeout", 32'(timeout), 32'(et));
      chk("hit_cnt", 32'(hit_cnt), 32'(ec));
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drv(input logic [NCH-1:0] ld, input logic [NCH-1:0] dn,
                      input logic [WIN_W-1:0] wl, input logic clr);
      load_mem = ld; done = dn; win_len = wl; cnt_clr = clr;
   endtask

   function automatic logic [CNT_W-1:0] cnt_of(input int ch);
      return hit_cnt[ch*CNT_W +: CNT_W];
   endfunction

   initial begin
      logic [NCH-1:0]   ld_v;
      logic [NCH-1:0]   dn_v;
      logic [WIN_W-1:0] wl_v;
      rst_n = 1'b0;
      drv(4'b0000, 4'b0000, 4'd0, 1'b0);
      model_reset();
      #1;
      compare_all();
      chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // ch0 hit three edges after the rise
      drv(4'b0001, 4'b0000, 4'd5, 1'b0); tick();
      tick(); tick();
      drv(4'b0001, 4'b0001, 4'd5, 1'b0); tick();
      chk("s1_ready", 32'(ready), 32'h1);
      chk("s1_cnt0", 32'(cnt_of(0)), 32'd1);
      drv(4'b0001, 4'b0000, 4'd5, 1'b0); tick();
      chk("s1_ready_gone", 32'(ready), 32'h0);
      drv(4'b0000, 4'b0000, 4'd5, 1'b0); tick();

      // ch1 no done: miss five edges after the rise
      drv(4'b0010, 4'b0000, 4'd5, 1'b0); tick();
      for (int k = 0; k < 4; k++) tick();
      chk("s2_no_early_to", 32'(timeout), 32'h0);
      tick();
      chk("s2_timeout", 32'(timeout), TO_EN ? 32'h2 : 32'h0);
      chk("s2_no_ready", 32'(ready), 32'h0);
      chk("s2_cnt1", 32'(cnt_of(1)), 32'd0);
      drv(4'b0000, 4'b0000, 4'd5, 1'b0); tick();

      // zero window: same-edge done hits, otherwise immediate miss
      drv(4'b0001, 4'b0001, 4'd0, 1'b0); tick();
      chk("s3_ready", 32'(ready), 32'h1);
      chk("s3_cnt0", 32'(cnt_of(0)), 32'd2);
      drv(4'b0000, 4'b0000, 4'd0, 1'b0); tick();
      drv(4'b0001, 4'b0000, 4'd0, 1'b0); tick();
      chk("s3_timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
      chk("s3_no_ready", 32'(ready), 32'h0);
      drv(4'b0000, 4'b0000, 4'd0, 1'b0); tick();

      // ch2: re-rise while armed and two done pulses -> one ready
      drv(4'b0100, 4'b0000, 4'd6, 1'b0); tick();
      drv(4'b0000, 4'b0000, 4'd6, 1'b0); tick();
      drv(4'b0100, 4'b0000, 4'd6, 1'b0); tick();
      drv(4'b0100, 4'b0100, 4'd6, 1'b0); tick();
      chk("s4_ready", 32'(ready), 32'h4);
      drv(4'b0100, 4'b0000, 4'd6, 1'b0); tick();
      drv(4'b0100, 4'b0100, 4'd6, 1'b0); tick();
      chk("s4_second_done", 32'(ready), 32'h0);
      chk("s4_cnt2", 32'(cnt_of(2)), 32'd1);
      drv(4'b0000, 4'b0000, 4'd6, 1'b0); tick();

      // reset while armed at count 3, load kept high through release
      drv(4'b0001, 4'b0000, 4'd5, 1'b0); tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("s5_rst_ready", 32'(ready), 32'h0);
      chk("s5_rst_timeout", 32'(timeout), 32'h0);
      chk("s5_rst_cnt", 32'(hit_cnt), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      drv(4'b0000, 4'b0000, 4'd5, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      chk("s5_post_rst_timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
      tick();

      // ch3 saturation, then clear colliding with a hit
      for (int k = 0; k < 5; k++) begin
         drv(4'b1000, 4'b1000, 4'd3, 1'b0); tick();
         drv(4'b0000, 4'b0000, 4'd3, 1'b0); tick();
      end
      chk("s6_sat", 32'(cnt_of(3)), 32'd3);
      drv(4'b1000, 4'b1000, 4'd3, 1'b1); tick();
      chk("s6_clr_wins", 32'(cnt_of(3)), 32'd0);
      chk("s6_clr_ready", 32'(ready), 32'h8);
      drv(4'b0000, 4'b0000, 4'd3, 1'b0); tick();

      // every channel hits on the same edge
      drv(4'b1111, 4'b1111, 4'd3, 1'b0); tick();
      chk("s7_ready_all", 32'(ready), 32'hF);
      chk("s7_ready_any", 32'(ready_any), 32'h1);
      drv(4'b1111, 4'b0000, 4'd3, 1'b0); tick();
      chk("s7_ready_off", 32'(ready), 32'h0);
      chk("s7_any_off", 32'(ready_any), 32'h0);
      drv(4'b0000, 4'b0000, 4'd3, 1'b0); tick();

      // randomized traffic against the model
      ld_v = 4'b0000;
      wl_v = 4'd3;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 3) == 0) ld_v[i] = ~ld_v[i];
            dn_v[i] = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 15) == 0) wl_v = WIN_W'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 499) != 0);
         drv(ld_v, dn_v, wl_v, $urandom_range(0, 63) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_multi_seq_trigger

// File: doc/multi_seq_trigger.md
MULTI_SEQ_TRIGGER -- requirements
Module: multi_seq_trigger

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent load/done channels (1..32).
REQ-002 SHALL have parameter WIN_W, default 4, width of the window-length input (max window 2**WIN_W-1 cycles).
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-channel hit counter.
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load_mem  input  NCH  per-channel memory-load request level.
REQ-007 SHALL have port done  input  NCH  per-channel load-complete indication.
REQ-008 SHALL have port win_len  input  WIN_W  global done window in cycles after load rise.
REQ-009 SHALL have port cnt_clr  input  1  synchronous clear of all hit counters.
REQ-010 SHALL have port ready  output  NCH  one-cycle per-channel completion pulse.
REQ-011 SHALL have port ready_any  output  1  OR of ready.
REQ-012 SHALL have port timeout  output  NCH  one-cycle per-channel window-expiry pulse (macro-gated).
REQ-013 SHALL have port hit_cnt  output  NCH*CNT_W  packed per-channel hit counters, channel 0 in LSBs.

Function
REQ-014 SHALL detect a rise per channel when load_mem[i] sampled 1 at current edge and 0 at previous edge.
REQ-015 SHALL implement per-channel FSM IDLE/ARMED; rise in IDLE with done[i]=1 same edge -> hit, stay IDLE.
REQ-016 SHALL, on rise in IDLE with done[i]=0, latch win_len, set cycle count to 1, enter ARMED.
REQ-017 SHALL in ARMED: done[i]=1 -> hit, IDLE; else count==latched window -> miss, IDLE; else count+1.
REQ-018 SHALL treat latched window 0 as same-edge-only: rise without done -> immediate miss.
REQ-019 SHALL implement first-match semantics: only the first done in a window produces a hit; later done ignored until next rise.
REQ-020 SHALL ignore rises occurring while ARMED (no restart, no re-latch).
REQ-021 SHALL register ready[i] high for exactly one cycle following the edge at which the hit is detected; timeout[i] likewise for a miss.
REQ-022 SHALL drive ready_any combinationally as OR of registered ready.
REQ-023 SHALL increment hit_cnt[i] on each hit, saturating at all-ones; cnt_clr has priority over increment.
REQ-024 SHALL keep channels fully independent; simultaneous hits on all channels all reported same cycle.
REQ-025 SHALL ignore win_len changes after latch for an armed channel.

Reset
REQ-026 SHALL on rst_n low asynchronously force all FSMs IDLE, previous-load registers 0, ready/timeout 0, hit_cnt 0.
REQ-027 SHALL abandon any armed window on reset mid-operation with no pulse emitted; load_mem already high at first edge after release counts as a rise.

Configuration
REQ-028 SHALL with SEQ_TRIG_TIMEOUT_EN defined drive timeout per REQ-017/021.
REQ-029 SHALL without SEQ_TRIG_TIMEOUT_EN tie timeout to 0 and omit its registers; hit behaviour unchanged.

Structure
REQ-030 SHALL place state enum (IDLE, ARMED) and default parameter constants in package seq_trig_pkg.
REQ-031 SHALL implement one channel as sub-module seq_trig_chan, instantiated NCH times via generate; counters may live in it.

Verification
REQ-032 SHALL test: win_len=5, ch0 load rise edge 10, done edge 13 -> ready[0] one cycle after edge 13, hit_cnt[0]=1.
REQ-033 SHALL test: win_len=5, ch1 rise edge 10, no done -> timeout[1] after edge 15, no ready, count unchanged.
REQ-034 SHALL test: win_len=0, rise with done same edge -> ready; rise without done -> timeout after that edge.
REQ-035 SHALL test: ch2 armed, second load rise and two done pulses -> exactly one ready, window not restarted.
REQ-036 SHALL test: rst_n low at ARMED count 3 -> no pulse, all outputs 0; CNT_W=2 with 5 hits -> hit_cnt=3; cnt_clr with hit same cycle -> 0.
REQ-037 SHALL test: all NCH channels hit same edge -> ready all ones, ready_any=1 for one cycle.
